// File: rtl/cpu_pkg.sv
// Shared pipeline-control encodings: hazard FSM states, forward-select codes
// and the hard-wired zero register default.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Truncated to REG_AW at the use site, so it is all-ones for any width.
  localparam logic [15:0] ZERO_REG_ALL = 16'hFFFF;

endpackage

// File: rtl/fwd_select.sv
// One ALU operand's bypass select: EX/MEM wins over MEM/WB, the zero register
// never forwards.
module fwd_select import cpu_pkg::*; #(
  parameter int                REG_AW   = 5,
  parameter logic [REG_AW-1:0] ZERO_REG = '1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd == rs) && (mem_rd != ZERO_REG))
      sel = FWD_MEM;
    else if (wb_regwrite && (wb_rd == rs) && (wb_rd != ZERO_REG))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding, load-use stall sequencing,
// taken-branch flush, and stall/flush performance counters.
module hazard_unit import cpu_pkg::*; #(
  parameter int                XLEN        = 64,
  parameter int                REG_AW      = 5,
  parameter int                LOAD_LAT    = 1,
  parameter int                FLUSH_DEPTH = 3,
  parameter logic [REG_AW-1:0] ZERO_REG    = REG_AW'(ZERO_REG_ALL)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic                   id_use1,
  input  logic                   id_use2,
  input  logic [REG_AW-1:0]      ex_rs1,
  input  logic [REG_AW-1:0]      ex_rs2,
  input  logic [REG_AW-1:0]      ex_rd,
  input  logic                   ex_memread,
  input  logic                   ex_regwrite,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic                   mem_regwrite,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic                   wb_regwrite,
  input  logic                   branch_taken,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_bubble,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt,
  output logic [1:0]             state
);

  if (XLEN < 1 || LOAD_LAT < 1 || LOAD_LAT > 7 || FLUSH_DEPTH < 1 || FLUSH_DEPTH > 4)
  begin : g_bad_param
    $error("hazard_unit: parameter out of range");
  end

  fwd_sel_e  a_sel, b_sel;
  hz_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use, br_ok;

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(a_sel)
  );

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(b_sel)
  );

  assign fwd_a_sel = reset ? FWD_RF : a_sel;
  assign fwd_b_sel = reset ? FWD_RF : b_sel;
  assign state     = state_q;

  always_comb
    load_use = ex_memread && ex_regwrite && (ex_rd != ZERO_REG) &&
               ((id_use1 && (ex_rd == id_rs1)) || (id_use2 && (ex_rd == id_rs2)));

  // The detection cycle is the first stall cycle, so STALL covers LOAD_LAT-1
  // more; cnt_q holds the stall cycles left including the current one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = '0;
    br_ok       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          br_ok   = 1'b1;
          flush   = '1;
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_STALL;
            cnt_d   = 3'(LOAD_LAT - 1);
          end
        end
      end
      ST_STALL: begin
        if (branch_taken) begin
          br_ok   = 1'b1;
          flush   = '1;
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Any branch_taken here belongs to a squashed instruction.
        flush   = '1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      state_d     = ST_RUN;
      cnt_d       = '0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      flush       = '0;
      br_ok       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (br_ok && (flush_cnt != 32'hFFFF_FFFF))     flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_unit;

  localparam int LL = 3;
  localparam int FD = 3;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use1, id_use2, ex_memread, ex_regwrite, mem_regwrite, wb_regwrite, branch_taken;
  logic [1:0] fwd_a_sel, fwd_b_sel, state;
  logic pc_write, ifid_write, idex_bubble;
  logic [FD-1:0] flush;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.XLEN(64), .REG_AW(5), .LOAD_LAT(LL), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining stall cycles, a flush-pending flag, event tallies.
  int          m_rem = 0;
  bit          m_flushing = 1'b0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flushes = '0;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (mem_regwrite && mem_rd == rs && mem_rd != 5'd31) return 2'b10;
    if (wb_regwrite && wb_rd == rs && wb_rd != 5'd31) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin : model
    bit lu, stl, br;
    logic [1:0] ea, eb, est;
    logic [FD-1:0] efl;
    lu  = ex_memread && ex_regwrite && ex_rd != 5'd31 &&
          ((id_use1 && ex_rd == id_rs1) || (id_use2 && ex_rd == id_rs2));
    est = m_flushing ? 2'b10 : (m_rem > 0 ? 2'b01 : 2'b00);
    ea = 2'b00; eb = 2'b00; efl = '0; stl = 1'b0; br = 1'b0;
    if (!reset) begin
      ea = m_fwd(ex_rs1);
      eb = m_fwd(ex_rs2);
      if (m_flushing) efl = '1;
      else if (branch_taken) begin br = 1'b1; efl = '1; end
      else if (m_rem > 0 || lu) stl = 1'b1;
    end
    chk("fwd_a", 64'(fwd_a_sel), 64'(ea));
    chk("fwd_b", 64'(fwd_b_sel), 64'(eb));
    chk("pc_write", 64'(pc_write), 64'(!stl));
    chk("ifid_write", 64'(ifid_write), 64'(!stl));
    chk("idex_bubble", 64'(idex_bubble), 64'(stl));
    chk("flush", 64'(flush), 64'(efl));
    chk("state", 64'(state), 64'(est));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flushes));
    if (reset) begin
      m_rem = 0; m_flushing = 1'b0; m_stalls = '0; m_flushes = '0;
    end else begin
      if (stl && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (br && m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
      if (m_flushing) m_flushing = 1'b0;
      else if (br) begin m_flushing = 1'b1; m_rem = 0; end
      else if (m_rem > 0) m_rem = m_rem - 1;
      else if (lu) m_rem = LL - 1;
    end
  end

  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use1, id_use2, ex_memread, ex_regwrite, mem_regwrite, wb_regwrite, branch_taken} = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    step(); reset = 1'b1; clr();
    step(); step(); reset = 1'b0;
  endtask

  task automatic load_hazard();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use1 = 1'b1;
  endtask

  function automatic logic [4:0] rreg();
    int unsigned r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    reset = 1'b1;
    clr();
    // Reset values, forwarding gated while reset is high.
    step(); step();
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1;
    look();
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_pc", 64'(pc_write), 64'(1));
    chk("rst_fwd_a", 64'(fwd_a_sel), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_cnt", 64'({stall_cnt, flush_cnt}), 64'(0));
    step(); reset = 1'b0; clr();

    // Forwarding priority.
    ex_rs1 = 5'd3; mem_rd = 5'd3; wb_rd = 5'd3; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    look(); chk("prio_mem", 64'(fwd_a_sel), 64'(2'b10));
    mem_regwrite = 1'b0; #1;
    chk("prio_wb", 64'(fwd_a_sel), 64'(2'b01));

    // Zero register never forwards or stalls.
    step(); clr();
    ex_rs2 = 5'd31; mem_rd = 5'd31; mem_regwrite = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd31; id_rs1 = 5'd31; id_use1 = 1'b1;
    look();
    chk("zr_fwd_b", 64'(fwd_b_sel), 64'(0));
    chk("zr_nostall", 64'(pc_write), 64'(1));
    step(); clr(); look();
    chk("zr_state", 64'(state), 64'(0));

    // Load-use: exactly LL stall cycles.
    do_reset();
    load_hazard(); look();
    chk("lu_c1_pc", 64'(pc_write), 64'(0));
    chk("lu_c1_bubble", 64'(idex_bubble), 64'(1));
    step(); clr(); look();
    chk("lu_c2", 64'({state, pc_write}), 64'({2'b01, 1'b0}));
    step(); look();
    chk("lu_c3", 64'({state, pc_write}), 64'({2'b01, 1'b0}));
    step(); look();
    chk("lu_done", 64'({state, pc_write}), 64'({2'b00, 1'b1}));
    chk("lu_stall_cnt", 64'(stall_cnt), 64'(3));

    // Branch in the second stall cycle aborts the stall.
    do_reset();
    load_hazard(); step(); clr();
    branch_taken = 1'b1; look();
    chk("bs_flush", 64'({flush, pc_write, idex_bubble}), 64'({3'b111, 1'b1, 1'b0}));
    step(); branch_taken = 1'b0; look();
    chk("bs_fstate", 64'({state, flush}), 64'({2'b10, 3'b111}));
    step(); look();
    chk("bs_run", 64'(state), 64'(0));
    chk("bs_cnts", 64'({stall_cnt, flush_cnt}), {32'd1, 32'd1});

    // Branch with load-use together: branch wins.
    do_reset();
    load_hazard(); branch_taken = 1'b1; look();
    chk("bl_pc", 64'({pc_write, idex_bubble, flush}), 64'({1'b1, 1'b0, 3'b111}));

    // Branch held through FLUSH counts once.
    do_reset();
    branch_taken = 1'b1; look();
    chk("bf_c1", 64'({state, flush}), 64'({2'b00, 3'b111}));
    step(); look();
    chk("bf_c2", 64'(state), 64'(2'b10));
    step(); branch_taken = 1'b0; look();
    chk("bf_c3", 64'({state, flush}), 64'({2'b00, 3'b000}));
    chk("bf_cnt", 64'(flush_cnt), 64'(1));

    // Reset mid-stall abandons the stall.
    do_reset();
    load_hazard(); step(); clr();
    reset = 1'b1; step(); reset = 1'b0; look();
    chk("rs_state", 64'({state, pc_write, flush}), 64'({2'b00, 1'b1, 3'b000}));
    chk("rs_cnts", 64'({stall_cnt, flush_cnt}), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      reset        = ($urandom_range(0, 79) == 0);
      id_rs1       = rreg(); id_rs2 = rreg();
      id_use1      = 1'($urandom); id_use2 = 1'($urandom);
      ex_rs1       = rreg(); ex_rs2 = rreg(); ex_rd = rreg();
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_regwrite  = ($urandom_range(0, 3) != 0);
      mem_rd       = rreg(); mem_regwrite = 1'($urandom);
      wb_rd        = rreg(); wb_regwrite = 1'($urandom);
      branch_taken = ($urandom_range(0, 9) == 0);
    end
    step(); reset = 1'b0; clr();
    step(); look();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
